// File: rtl/avl_bus_ram_slave.sv
// Avalon-style word-addressed RAM responder: single/burst reads and writes with
// programmable accept wait states and read latency.
module avl_bus_ram_slave #(
  parameter int    SIZE         = 65536,
  parameter int    WAIT_CYCLES  = 0,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] avl_s_address,
  input  logic [3:0]  avl_s_byte_en,
  input  logic        avl_s_read,
  input  logic        avl_s_write,
  input  logic [31:0] avl_s_write_data,
  input  logic        avl_s_begin_burst_transfer,
  input  logic [7:0]  avl_s_burst_count,
  output logic [31:0] avl_s_read_data,
  output logic        avl_s_read_data_valid,
  output logic        avl_s_wait_request
);

  localparam int         AW      = $clog2(SIZE) - 2;
  localparam int         WORDS   = SIZE / 4;
  localparam logic [2:0] WAIT_C  = 3'(WAIT_CYCLES);
  localparam logic       LAT1    = (READ_LATENCY == 1) ? 1'b1 : 1'b0;
  localparam logic [1:0] LAT_PRE = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;
  localparam logic [AW-1:0] ONE_W = AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   mem_r [0:WORDS-1];
  logic [2:0]    cnt_r, cnt_s;
  logic [AW-1:0] wr_addr_r, rd_addr_r, base_s, waddr_s, raddr_s;
  logic [7:0]    wr_rem_r, rd_rem_r, blen_s;
  logic [1:0]    rd_dly_r;
  logic [31:0]   read_data_r;
  logic          read_data_valid_r;
  logic          req_s, acc_wr_s, acc_rd_s, we_s, issue_s, wait_s;
  logic          unused_addr_s;

  assign req_s  = avl_s_read | avl_s_write;
  assign base_s = avl_s_address[AW+1:2];
  assign blen_s = (avl_s_begin_burst_transfer && (avl_s_burst_count != 8'd0)) ?
                  avl_s_burst_count : 8'd1;
  assign unused_addr_s = ^{avl_s_address[31:AW+2], avl_s_address[1:0]};

  // State register
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next state, acceptance, RAM port selection and beat issue
  always_comb begin
    state_s  = state_r;
    cnt_s    = 3'd0;
    wait_s   = 1'b1;
    acc_wr_s = 1'b0;
    acc_rd_s = 1'b0;
    we_s     = 1'b0;
    waddr_s  = wr_addr_r;
    issue_s  = 1'b0;
    raddr_s  = rd_addr_r;
    case (state_r)
      IDLE: begin
        // A simultaneous read stays pending, so wait_request stays high for it
        if (req_s && (cnt_r == WAIT_C)) begin
          acc_wr_s = avl_s_write;
          acc_rd_s = ~avl_s_write;
          wait_s   = avl_s_read & avl_s_write;
        end else if (req_s) begin
          cnt_s = cnt_r + 3'd1;
        end else begin
          wait_s = 1'b0;
        end
        we_s    = acc_wr_s;
        waddr_s = base_s;
        raddr_s = base_s;
        issue_s = acc_rd_s & LAT1;
        if (acc_wr_s) begin
          state_s = (blen_s == 8'd1) ? IDLE : WR;
        end else if (acc_rd_s) begin
          state_s = RD;
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (rd_rem_r == 8'd0) begin
          state_s = IDLE;
        end else begin
          issue_s = (rd_dly_r == 2'd0);
        end
      end
      WR: begin
        wait_s = 1'b0;
        we_s   = avl_s_write;
        if (avl_s_write && (wr_rem_r == 8'd1)) begin
          state_s = IDLE;
        end else begin
          state_s = WR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Wait counter, burst bookkeeping and registered read port
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      cnt_r             <= 3'd0;
      wr_addr_r         <= '0;
      wr_rem_r          <= 8'd0;
      rd_addr_r         <= '0;
      rd_rem_r          <= 8'd0;
      rd_dly_r          <= 2'd0;
      read_data_r       <= 32'd0;
      read_data_valid_r <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      if (acc_wr_s) begin
        wr_addr_r <= base_s + ONE_W;
        wr_rem_r  <= blen_s - 8'd1;
      end else if ((state_r == WR) && avl_s_write) begin
        wr_addr_r <= wr_addr_r + ONE_W;
        wr_rem_r  <= wr_rem_r - 8'd1;
      end
      // With latency 1 the first beat leaves on the accept edge itself
      if (acc_rd_s) begin
        if (LAT1) begin
          rd_addr_r <= base_s + ONE_W;
          rd_rem_r  <= blen_s - 8'd1;
          rd_dly_r  <= 2'd0;
        end else begin
          rd_addr_r <= base_s;
          rd_rem_r  <= blen_s;
          rd_dly_r  <= LAT_PRE;
        end
      end else if (state_r == RD) begin
        if (rd_dly_r != 2'd0) begin
          rd_dly_r <= rd_dly_r - 2'd1;
        end else if (issue_s) begin
          rd_addr_r <= rd_addr_r + ONE_W;
          rd_rem_r  <= rd_rem_r - 8'd1;
        end
      end
      read_data_valid_r <= issue_s;
      if (issue_s) read_data_r <= mem_r[raddr_s];
    end
  end

  // RAM write port with per-byte enables; contents survive reset
  always_ff @(posedge clk) begin
    if (we_s && rest) begin
      for (int b = 0; b < 4; b++) begin
        if (avl_s_byte_en[b]) mem_r[waddr_s][8*b +: 8] <= avl_s_write_data[8*b +: 8];
      end
    end
  end

  assign avl_s_read_data       = read_data_r;
  assign avl_s_read_data_valid = read_data_valid_r;
  assign avl_s_wait_request    = ~rest | wait_s;

endmodule

// File: tb/tb_avl_bus_ram_slave.sv
// Bench for avl_bus_ram_slave: two instances (no-wait/latency-1 and wait-3/latency-4),
// vector table, corner-case sequences and random traffic against a word-array model.
module tb_avl_bus_ram_slave;
  localparam int SZ = 1024;
  localparam int NW = SZ / 4;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rd, wr, bb;
  logic [7:0]  bc;
  logic        sel;
  logic [31:0] rdata0, rdata1, rdata;
  logic        rv0, rv1, rv, wq0, wq1, wq;

  logic [31:0] mdl   [0:1][0:NW-1];
  bit          known [0:1][0:NW-1];
  logic [31:0] wbuf  [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avl_bus_ram_slave #(.SIZE(SZ), .WAIT_CYCLES(0), .READ_LATENCY(1)) u_d0 (
    .clk(clk), .rest(rest), .avl_s_address(addr), .avl_s_byte_en(be),
    .avl_s_read(rd && !sel), .avl_s_write(wr && !sel), .avl_s_write_data(wdata),
    .avl_s_begin_burst_transfer(bb), .avl_s_burst_count(bc),
    .avl_s_read_data(rdata0), .avl_s_read_data_valid(rv0), .avl_s_wait_request(wq0));

  avl_bus_ram_slave #(.SIZE(SZ), .WAIT_CYCLES(3), .READ_LATENCY(4)) u_d1 (
    .clk(clk), .rest(rest), .avl_s_address(addr), .avl_s_byte_en(be),
    .avl_s_read(rd && sel), .avl_s_write(wr && sel), .avl_s_write_data(wdata),
    .avl_s_begin_burst_transfer(bb), .avl_s_burst_count(bc),
    .avl_s_read_data(rdata1), .avl_s_read_data_valid(rv1), .avl_s_wait_request(wq1));

  assign rdata = sel ? rdata1 : rdata0;
  assign rv    = sel ? rv1 : rv0;
  assign wq    = sel ? wq1 : wq0;

  function automatic int wexp();
    return sel ? 3 : 0;
  endfunction

  function automatic int lat();
    return sel ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t dut=%0d)", nm, act, exp, $time, sel);
    end
  endtask

  function automatic void mupd(input int i, input logic [31:0] d, input logic [3:0] b);
    for (int j = 0; j < 4; j++) begin
      if (b[j]) mdl[sel][i][8*j +: 8] = d[8*j +: 8];
    end
    if (b == 4'hF) known[sel][i] = 1'b1;
  endfunction

  task automatic idle_bus();
    rd = 1'b0; wr = 1'b0; bb = 1'b0; bc = 8'd0;
  endtask

  task automatic wait_accept(input string nm);
    int waits;
    waits = 0;
    @(negedge clk);
    while (wq && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    chk(nm, waits, wexp());
  endtask

  // n = 0 drives burst_count 0 with begin_burst, which must act as one beat
  task automatic bus_write(input logic [31:0] a, input int n, input logic [3:0] b,
                           input logic [15:0] gap);
    int nb, idx;
    nb  = (n == 0) ? 1 : n;
    idx = int'(a[9:2]);
    @(posedge clk); #1;
    addr = a; wdata = wbuf[0]; be = b; wr = 1'b1; rd = 1'b0;
    bb = (n != 1); bc = 8'(n);
    wait_accept("wr_waits");
    @(posedge clk);
    mupd(idx, wbuf[0], b);
    for (int k = 1; k < nb; k++) begin
      #1;
      bb = 1'b0; bc = 8'd0;
      if (k < 16 && gap[k]) begin
        wr = 1'b0; wdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("wr_gap_wq", wq, 1'b0);
        @(posedge clk); #1;
      end
      wr = 1'b1; wdata = wbuf[k];
      @(negedge clk);
      chk("wr_beat_wq", wq, 1'b0);
      @(posedge clk);
      mupd((idx + k) % NW, wbuf[k], b);
    end
    #1;
    idle_bus();
  endtask

  task automatic bus_read(input logic [31:0] a, input int n, output logic [31:0] first);
    int nb, idx, l, j;
    bit ev;
    nb  = (n == 0) ? 1 : n;
    idx = int'(a[9:2]);
    l   = lat();
    first = 32'hxxxxxxxx;
    @(posedge clk); #1;
    addr = a; rd = 1'b1; wr = 1'b0; bb = (n != 1); bc = 8'(n);
    wait_accept("rd_waits");
    @(posedge clk); #1;
    idle_bus();
    for (int c = 1; c <= l + nb; c++) begin
      @(negedge clk);
      ev = (c >= l) && (c <= l + nb - 1);
      chk("rd_valid", rv, ev);
      if (c < l + nb) chk("rd_busy_wq", wq, 1'b1);
      else            chk("rd_idle_wq", wq, 1'b0);
      if (ev) begin
        j = (idx + c - l) % NW;
        if (c == l) first = rdata;
        if (known[sel][j]) chk("rd_data", rdata, mdl[sel][j]);
      end else if (c == l + nb) begin
        j = (idx + nb - 1) % NW;
        if (known[sel][j]) chk("rd_hold", rdata, mdl[sel][j]);
      end
    end
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    int          n;
    logic [31:0] e;
  } vec_t;

  vec_t tv [0:5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first;
    int beats, cyc;

    tv[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEADBEEF, 4'hF, 1, 32'h0};
    tv[1] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 1, 32'hDEADBEEF};
    tv[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h11223344, 4'b0101, 1, 32'h0};
    tv[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 1, 32'hDE22BE44};
    tv[4] = '{1'b0, 1'b0, 32'hFFFF_F100, 32'h0,        4'h0, 0, 32'hDE22BE44};
    tv[5] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFEF00D, 4'hF, 1, 32'h0};

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NW; i++) begin
        mdl[s][i]   = 32'h0;
        known[s][i] = 1'b0;
      end

    rest = 1'b0; sel = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    idle_bus();
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      chk("rst_wq", wq, 1'b1);
      chk("rst_rv", rv, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rest = 1'b1;

    for (int i = 0; i < 6; i++) begin
      sel = tv[i].s;
      if (tv[i].w) begin
        wbuf[0] = tv[i].d;
        bus_write(tv[i].a, tv[i].n, tv[i].b, 16'h0);
      end else begin
        bus_read(tv[i].a, tv[i].n, first);
        chk("tv_first", first, tv[i].e);
      end
    end
    sel = 1'b1;
    bus_read(32'h0000_0206, 1, first);
    chk("tv_lowbits", first, 32'hCAFEF00D);

    // ramp preload, then a 16-beat read under waits and latency 4
    for (int k = 0; k < 16; k++) wbuf[k] = 32'(k);
    bus_write(32'h0, 16, 4'hF, 16'h0);
    bus_read(32'h0, 16, first);
    chk("ramp_first", first, 32'h0);

    // reset after 5 of 16 beats
    @(posedge clk); #1;
    addr = 32'h0; rd = 1'b1; bb = 1'b1; bc = 8'd16;
    wait_accept("rst6_waits");
    @(posedge clk); #1;
    idle_bus();
    beats = 0; cyc = 0;
    while (beats < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rv) beats++;
    end
    chk("rst6_beats", beats, 5);
    #1 rest = 1'b0;
    #1;
    chk("rst6_rv", rv, 1'b0);
    chk("rst6_wq", wq, 1'b1);
    chk("rst6_rdata", rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst6_rv_hold", rv, 1'b0);
    end
    rest = 1'b1;
    bus_read(32'h0, 16, first);
    chk("rst6_after", first, 32'h0);

    // wrapping write burst with gaps after beats 2 and 5
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hA500_0000 + 32'(k);
    bus_write(32'(SZ - 16), 8, 4'hF, 16'h0024);
    bus_read(32'(SZ - 16), 8, first);
    chk("wrap_first", first, 32'hA500_0000);
    bus_read(32'h0, 4, first);
    chk("wrap_low", first, 32'hA500_0004);

    // read and write together: write wins, read follows with new data
    sel = 1'b0;
    @(posedge clk); #1;
    addr = 32'h300; wdata = 32'h5A5A1234; be = 4'hF; wr = 1'b1; rd = 1'b1; bb = 1'b0; bc = 8'd1;
    @(negedge clk);
    chk("both_wq", wq, 1'b1);
    @(posedge clk);
    mupd(int'(addr[9:2]), wdata, 4'hF);
    #1 wr = 1'b0;
    @(negedge clk);
    chk("both_rd_wq", wq, 1'b0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("both_rv", rv, 1'b1);
    chk("both_rdata", rdata, 32'h5A5A1234);
    @(negedge clk);
    chk("both_rv_end", rv, 1'b0);

    // random traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int t = 0; t < 30; t++) begin
        int n;
        logic [31:0] a;
        logic [3:0] b;
        n = $urandom_range(0, 6);
        a = $urandom;
        if ($urandom_range(0, 1) == 0) begin
          b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
          bus_write(a, n, b, 16'($urandom) & 16'h00FE);
        end else begin
          bus_read(a, n, first);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
